// File: rtl/stage3_execute.sv
// Execute stage: ALU, branch/jump resolution, zero/neg flag register and
// the EX/MEM pipeline register with stall (hold) and flush (bubble) control.
module stage3_execute #(
    parameter int DW = 32,
    parameter int RW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] in_imm,
    input  logic [RW-1:0] in_rd,
    input  logic [DW-1:0] in_rd1,
    input  logic [DW-1:0] in_rd2,
    input  logic [DW-1:0] in_PC,
    input  logic          in_brz,
    input  logic          in_brn,
    input  logic          in_j,
    input  logic          in_regw,
    input  logic          in_wai,
    input  logic          in_memw,
    input  logic          in_memr,
    input  logic          in_alusrc,
    input  logic [2:0]    in_aluop,
    output logic          flag_z,
    output logic          flag_n,
    output logic          redirect,
    output logic [DW-1:0] redirect_pc,
    output logic          out_valid,
    output logic [DW-1:0] out_alu,
    output logic [DW-1:0] out_rd2,
    output logic [RW-1:0] out_rd,
    output logic [DW-1:0] out_PC,
    output logic          out_regw,
    output logic          out_wai,
    output logic          out_memw,
    output logic          out_memr
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_NEG   = 3'b010;
    localparam logic [2:0] OP_PASSA = 3'b011;
    localparam logic [2:0] OP_PASSB = 3'b100;

    logic [DW-1:0] operand_b_s;
    logic [DW-1:0] alu_s;
    logic          load_s;
    logic          flag_upd_s;

    logic          flag_z_r;
    logic          flag_n_r;
    logic          valid_r;
    logic [DW-1:0] alu_r;
    logic [DW-1:0] rd2_r;
    logic [RW-1:0] rd_r;
    logic [DW-1:0] pc_r;
    logic          regw_r;
    logic          wai_r;
    logic          memw_r;
    logic          memr_r;

    // Operand B select and the ALU itself (wraps modulo 2^DW).
    always_comb begin
        operand_b_s = in_rd2;
        alu_s       = {DW{1'b0}};
        if (in_alusrc) begin
            operand_b_s = in_imm;
        end else begin
            operand_b_s = in_rd2;
        end
        case (in_aluop)
            OP_ADD:   alu_s = in_rd1 + operand_b_s;
            OP_SUB:   alu_s = in_rd1 - operand_b_s;
            OP_NEG:   alu_s = {DW{1'b0}} - in_rd1;
            OP_PASSA: alu_s = in_rd1;
            OP_PASSB: alu_s = operand_b_s;
            default:  alu_s = {DW{1'b0}};
        endcase
    end

    // Redirect uses the registered (older) flags, never the in-flight result.
    always_comb begin
        redirect    = in_valid & ~flush &
                      (in_j | (in_brz & flag_z_r) | (in_brn & flag_n_r));
        redirect_pc = in_rd1;
    end

    // The register loads a real slot only when neither held nor flushed;
    // only register-writing non-load instructions update the flags.
    always_comb begin
        load_s     = ~stall & ~flush;
        flag_upd_s = load_s & in_valid & in_regw & ~in_memr;
    end

    // EX/MEM register: reset, hold on stall, bubble on flush, else load.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            alu_r   <= {DW{1'b0}};
            rd2_r   <= {DW{1'b0}};
            rd_r    <= {RW{1'b0}};
            pc_r    <= {DW{1'b0}};
            regw_r  <= 1'b0;
            wai_r   <= 1'b0;
            memw_r  <= 1'b0;
            memr_r  <= 1'b0;
        end else if (stall) begin
            valid_r <= valid_r;
        end else if (flush) begin
            // Data fields are don't-care in a bubble; loading them is harmless.
            valid_r <= 1'b0;
            alu_r   <= alu_s;
            rd2_r   <= in_rd2;
            rd_r    <= in_rd;
            pc_r    <= in_PC;
            regw_r  <= 1'b0;
            wai_r   <= 1'b0;
            memw_r  <= 1'b0;
            memr_r  <= 1'b0;
        end else begin
            valid_r <= in_valid;
            alu_r   <= alu_s;
            rd2_r   <= in_rd2;
            rd_r    <= in_rd;
            pc_r    <= in_PC;
            regw_r  <= in_regw & in_valid;
            wai_r   <= in_wai  & in_valid;
            memw_r  <= in_memw & in_valid;
            memr_r  <= in_memr & in_valid;
        end
    end

    // Architectural zero/neg flags fed back to decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z_r <= 1'b0;
            flag_n_r <= 1'b0;
        end else if (flag_upd_s) begin
            flag_z_r <= (alu_s == {DW{1'b0}});
            flag_n_r <= alu_s[DW-1];
        end else begin
            flag_z_r <= flag_z_r;
            flag_n_r <= flag_n_r;
        end
    end

    assign flag_z    = flag_z_r;
    assign flag_n    = flag_n_r;
    assign out_valid = valid_r;
    assign out_alu   = alu_r;
    assign out_rd2   = rd2_r;
    assign out_rd    = rd_r;
    assign out_PC    = pc_r;
    assign out_regw  = regw_r;
    assign out_wai   = wai_r;
    assign out_memw  = memw_r;
    assign out_memr  = memr_r;

endmodule

// File: tb/tb_stage3_execute.sv
// Directed self-checking bench for the execute stage.
module tb_stage3_execute;

    localparam int DW = 32;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          rst, in_valid, stall, flush;
    logic [DW-1:0] in_imm, in_rd1, in_rd2, in_PC;
    logic [RW-1:0] in_rd;
    logic          in_brz, in_brn, in_j;
    logic          in_regw, in_wai, in_memw, in_memr, in_alusrc;
    logic [2:0]    in_aluop;
    logic          flag_z, flag_n, redirect, out_valid;
    logic [DW-1:0] redirect_pc, out_alu, out_rd2, out_PC;
    logic [RW-1:0] out_rd;
    logic          out_regw, out_wai, out_memw, out_memr;

    int checks_s   = 0;
    int failures_s = 0;

    stage3_execute #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .in_imm(in_imm), .in_rd(in_rd), .in_rd1(in_rd1), .in_rd2(in_rd2),
        .in_PC(in_PC), .in_brz(in_brz), .in_brn(in_brn), .in_j(in_j),
        .in_regw(in_regw), .in_wai(in_wai), .in_memw(in_memw), .in_memr(in_memr),
        .in_alusrc(in_alusrc), .in_aluop(in_aluop),
        .flag_z(flag_z), .flag_n(flag_n), .redirect(redirect),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_alu(out_alu),
        .out_rd2(out_rd2), .out_rd(out_rd), .out_PC(out_PC),
        .out_regw(out_regw), .out_wai(out_wai), .out_memw(out_memw),
        .out_memr(out_memr)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_s = checks_s + 1;
        if (obs !== exp) begin
            failures_s = failures_s + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        in_imm = 32'h0; in_rd = 6'd0; in_rd1 = 32'h0; in_rd2 = 32'h0; in_PC = 32'h0;
        in_brz = 1'b0; in_brn = 1'b0; in_j = 1'b0;
        in_regw = 1'b0; in_wai = 1'b0; in_memw = 1'b0; in_memr = 1'b0;
        in_alusrc = 1'b0; in_aluop = 3'b000;
    endtask

    task automatic alu_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        clear_inputs();
        in_aluop = op; in_rd1 = a; in_rd2 = b; in_regw = 1'b1;
    endtask

    initial begin
        // Reset wins over stall, with a live instruction present.
        clear_inputs();
        rst = 1'b1; stall = 1'b1; in_regw = 1'b1; in_rd1 = 32'd5; in_rd2 = 32'd7;
        in_PC = 32'h44; in_memw = 1'b1;
        step();
        step();
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_alu",   {32'd0, out_alu},   64'd0);
        check("rst_pc",    {32'd0, out_PC},    64'd0);
        check("rst_regw",  {63'd0, out_regw},  64'd0);
        check("rst_memw",  {63'd0, out_memw},  64'd0);
        check("rst_fz",    {63'd0, flag_z},    64'd0);
        check("rst_fn",    {63'd0, flag_n},    64'd0);
        rst = 1'b0;

        // ADD 5+7
        alu_op(3'b000, 32'd5, 32'd7); in_rd = 6'd9; in_PC = 32'h100; in_wai = 1'b1;
        step();
        check("add_alu",   {32'd0, out_alu}, 64'd12);
        check("add_valid", {63'd0, out_valid}, 64'd1);
        check("add_regw",  {63'd0, out_regw}, 64'd1);
        check("add_wai",   {63'd0, out_wai}, 64'd1);
        check("add_rd",    {58'd0, out_rd}, 64'd9);
        check("add_pc",    {32'd0, out_PC}, 64'h100);
        check("add_fz",    {63'd0, flag_z}, 64'd0);
        check("add_fn",    {63'd0, flag_n}, 64'd0);

        // SUB 3-3 -> zero
        alu_op(3'b001, 32'd3, 32'd3);
        step();
        check("sub_alu", {32'd0, out_alu}, 64'd0);
        check("sub_fz",  {63'd0, flag_z}, 64'd1);
        check("sub_fn",  {63'd0, flag_n}, 64'd0);

        // NEG 1 -> all ones, negative
        alu_op(3'b010, 32'd1, 32'd0);
        step();
        check("neg_alu", {32'd0, out_alu}, 64'hFFFF_FFFF);
        check("neg_fn",  {63'd0, flag_n}, 64'd1);
        check("neg_fz",  {63'd0, flag_z}, 64'd0);

        // BRN taken on flag_n=1
        clear_inputs(); in_brn = 1'b1; in_rd1 = 32'h40; in_aluop = 3'b011;
        #1;
        check("brn_redir",    {63'd0, redirect}, 64'd1);
        check("brn_redir_pc", {32'd0, redirect_pc}, 64'h40);
        flush = 1'b1;
        #1;
        check("brn_flush_redir", {63'd0, redirect}, 64'd0);
        flush = 1'b0;
        step();
        check("brn_fn_hold", {63'd0, flag_n}, 64'd1);
        check("brn_regw",    {63'd0, out_regw}, 64'd0);

        // Clear flag_n with ADD 5+7, then BRN not taken, BRZ not taken, J taken
        alu_op(3'b000, 32'd5, 32'd7);
        step();
        check("clr_fn", {63'd0, flag_n}, 64'd0);
        clear_inputs(); in_brn = 1'b1; in_rd1 = 32'h40;
        #1;
        check("brn_nt", {63'd0, redirect}, 64'd0);
        in_brn = 1'b0; in_brz = 1'b1;
        #1;
        check("brz_nt", {63'd0, redirect}, 64'd0);
        in_brz = 1'b0; in_j = 1'b1;
        #1;
        check("j_taken", {63'd0, redirect}, 64'd1);

        // Set flag_z, then a load must not disturb it.
        alu_op(3'b001, 32'd3, 32'd3);
        step();
        clear_inputs(); in_alusrc = 1'b1; in_imm = 32'h10; in_rd1 = 32'h100;
        in_rd2 = 32'hDEAD; in_memr = 1'b1; in_regw = 1'b1; in_rd = 6'd33;
        step();
        check("ld_alu",  {32'd0, out_alu}, 64'h110);
        check("ld_memr", {63'd0, out_memr}, 64'd1);
        check("ld_rd2",  {32'd0, out_rd2}, 64'hDEAD);
        check("ld_rd",   {58'd0, out_rd}, 64'd33);
        check("ld_fz",   {63'd0, flag_z}, 64'd1);

        // PASS B via immediate, SUB wrap, reserved op -> 0
        clear_inputs(); in_aluop = 3'b100; in_alusrc = 1'b1; in_imm = 32'h1234;
        in_rd2 = 32'h9; in_memw = 1'b1;
        step();
        check("passb_alu",  {32'd0, out_alu}, 64'h1234);
        check("passb_memw", {63'd0, out_memw}, 64'd1);
        check("st_fz",      {63'd0, flag_z}, 64'd1);
        alu_op(3'b001, 32'd0, 32'd1);
        step();
        check("subwrap_alu", {32'd0, out_alu}, 64'hFFFF_FFFF);
        check("subwrap_fn",  {63'd0, flag_n}, 64'd1);
        alu_op(3'b110, 32'd7, 32'd7);
        step();
        check("rsvd_alu", {32'd0, out_alu}, 64'd0);
        check("rsvd_fz",  {63'd0, flag_z}, 64'd1);

        // Stall holds EX/MEM and flags
        alu_op(3'b000, 32'd4, 32'd5);
        step();
        check("pre_stall_alu", {32'd0, out_alu}, 64'd9);
        for (int i = 0; i < 3; i++) begin
            alu_op(3'b010, 32'd1 + i, 32'd0);
            stall = 1'b1;
            step();
            check("stall_alu", {32'd0, out_alu}, 64'd9);
        end
        check("stall_fn", {63'd0, flag_n}, 64'd0);
        flush = 1'b1;
        step();
        check("stallflush_alu",   {32'd0, out_alu}, 64'd9);
        check("stallflush_valid", {63'd0, out_valid}, 64'd1);
        stall = 1'b0;
        step();
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_regw",  {63'd0, out_regw}, 64'd0);
        check("flush_fn",    {63'd0, flag_n}, 64'd0);
        check("flush_fz",    {63'd0, flag_z}, 64'd0);

        // Bubble never writes and never redirects
        alu_op(3'b010, 32'd1, 32'd0); in_valid = 1'b0; in_memw = 1'b1; in_j = 1'b1;
        #1;
        check("bubble_redir", {63'd0, redirect}, 64'd0);
        step();
        check("bubble_valid", {63'd0, out_valid}, 64'd0);
        check("bubble_regw",  {63'd0, out_regw}, 64'd0);
        check("bubble_memw",  {63'd0, out_memw}, 64'd0);
        check("bubble_fn",    {63'd0, flag_n}, 64'd0);

        // Reset mid-stall clears everything
        alu_op(3'b001, 32'd3, 32'd3);
        step();
        check("pre_rst_fz", {63'd0, flag_z}, 64'd1);
        stall = 1'b1; rst = 1'b1;
        step();
        check("rst2_fz",    {63'd0, flag_z}, 64'd0);
        check("rst2_valid", {63'd0, out_valid}, 64'd0);
        check("rst2_regw",  {63'd0, out_regw}, 64'd0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
        $finish;
    end

endmodule
